fcounter_mc: RTL and testbench

- Multi-channel frequency counter, fully synchronous to `clk`.
- Counts rising edges of CH asynchronous measured signals over a programmable gate window of `clk` cycles.
- Supports single-shot and continuous modes, per-channel saturation/overflow flags and a one-cycle result-valid strobe.
- Sits on the instruments bus beside the other measurement blocks, using the same ce/som/eom handshake.

---
 rtl/fcounter_mc.sv | 133 +++++++++++++
 tb/tb_fcounter_mc.sv | 410 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fcounter_mc.sv
// fcounter_mc: multi-channel frequency counter over a programmable
// gate window, single-shot or continuous, with per-channel saturation.
module fcounter_mc #(
  parameter int N    = 16,
  parameter int CH   = 4,
  parameter int GW   = 16,
  parameter int SYNC = 2
) (
  input  logic            clk,
  input  logic            rstb,
  input  logic [CH-1:0]   ms_in,
  input  logic            fcounter_ce,
  input  logic            fcounter_som,
  input  logic            fcounter_mode,
  input  logic [GW-1:0]   fcounter_gate,
  output logic            fcounter_eom,
  output logic            fcounter_rdy,
  output logic            fcounter_valid,
  output logic [CH*N-1:0] fcounter_adata,
  output logic [CH-1:0]   fcounter_ovf
);

  typedef enum logic {IDLE, MEAS} state_t;

  localparam logic [GW:0] GONE = {{GW{1'b0}}, 1'b1};

  state_t                   state;
  logic [CH-1:0][SYNC-1:0]  sync_q;
  logic [CH-1:0]            edge_q;
  logic [CH-1:0]            det;
  logic [GW:0]              gate_cnt;
  logic [GW:0]              gate_ld;
  logic                     last;
  logic [CH-1:0][N-1:0]     cnt;
  logic [CH-1:0][N-1:0]     cnt_nx;
  logic [CH-1:0]            sat;
  logic [CH-1:0]            sat_nx;

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      sync_q <= '0;
      edge_q <= '0;
    end else begin
      for (int k = 0; k < CH; k++) begin
        sync_q[k] <= {sync_q[k][SYNC-2:0], ms_in[k]};
        edge_q[k] <= sync_q[k][SYNC-1];
      end
    end
  end

  always_comb begin
    det = '0;
    for (int k = 0; k < CH; k++)
      det[k] = sync_q[k][SYNC-1] & ~edge_q[k];
  end

  // Zero gate length still yields a one-cycle window
  always_comb begin
    gate_ld = {1'b0, fcounter_gate};
    if (fcounter_gate == '0)
      gate_ld = GONE;
  end

  assign last = (gate_cnt == GONE);

  always_comb begin
    cnt_nx = cnt;
    sat_nx = sat;
    for (int k = 0; k < CH; k++) begin
      if (det[k]) begin
        if (cnt[k] == '1)
          sat_nx[k] = 1'b1;
        else
          cnt_nx[k] = cnt[k] + N'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rstb) begin
    if (!rstb) begin
      state          <= IDLE;
      gate_cnt       <= '0;
      cnt            <= '0;
      sat            <= '0;
      fcounter_eom   <= 1'b1;
      fcounter_rdy   <= 1'b0;
      fcounter_valid <= 1'b0;
      fcounter_adata <= '0;
      fcounter_ovf   <= '0;
    end else begin
      fcounter_valid <= 1'b0;
      fcounter_rdy   <= (state == IDLE) & fcounter_ce;
      unique case (state)
        IDLE: begin
          if (fcounter_ce && fcounter_som) begin
            state        <= MEAS;
            gate_cnt     <= gate_ld;
            cnt          <= '0;
            sat          <= '0;
            fcounter_eom <= 1'b0;
          end
        end
        MEAS: begin
          if (!fcounter_ce) begin
            state        <= IDLE;
            gate_cnt     <= '0;
            fcounter_eom <= 1'b1;
          end else if (last) begin
            fcounter_adata <= cnt_nx;
            fcounter_ovf   <= sat_nx;
            fcounter_valid <= 1'b1;
            // Continuous: the next window opens on this edge, no gap
            if (fcounter_mode) begin
              gate_cnt <= gate_ld;
              cnt      <= '0;
              sat      <= '0;
            end else begin
              state        <= IDLE;
              gate_cnt     <= '0;
              fcounter_eom <= 1'b1;
            end
          end else begin
            gate_cnt <= gate_cnt - GONE;
            cnt      <= cnt_nx;
            sat      <= sat_nx;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fcounter_mc.sv
// tb_fcounter_mc: directed bench for fcounter_mc, main instance plus
// a narrow-counter instance for saturation.
module tb_fcounter_mc;

  logic        clk = 1'b0;
  logic        rstb;
  logic [3:0]  ms_in;
  logic        ce, som, mode;
  logic [15:0] gate;

  logic        eom, rdy, valid;
  logic [63:0] adata;
  logic [3:0]  ovf;
  logic        eom4, rdy4, valid4;
  logic [15:0] adata4;
  logic [3:0]  ovf4;

  logic        en0, en1;
  logic [3:0]  man;
  logic [3:0]  gen;
  logic [1:0]  ph;

  int checks = 0;
  int errors = 0;

  assign ms_in = gen | man;

  fcounter_mc #(.N(16), .CH(4), .GW(16), .SYNC(2)) u_dut (
    .clk(clk), .rstb(rstb), .ms_in(ms_in),
    .fcounter_ce(ce), .fcounter_som(som),
    .fcounter_mode(mode), .fcounter_gate(gate),
    .fcounter_eom(eom), .fcounter_rdy(rdy),
    .fcounter_valid(valid), .fcounter_adata(adata),
    .fcounter_ovf(ovf)
  );

  fcounter_mc #(.N(4), .CH(4), .GW(16), .SYNC(2)) u_sat (
    .clk(clk), .rstb(rstb), .ms_in(ms_in),
    .fcounter_ce(ce), .fcounter_som(som),
    .fcounter_mode(mode), .fcounter_gate(gate),
    .fcounter_eom(eom4), .fcounter_rdy(rdy4),
    .fcounter_valid(valid4), .fcounter_adata(adata4),
    .fcounter_ovf(ovf4)
  );

  always #5 clk = ~clk;

  // ch0: period 4 (2 high / 2 low), ch1: period 2
  initial begin
    ph  = 2'd0;
    gen = 4'd0;
    forever begin
      @(negedge clk);
      ph = ph + 2'd1;
      gen[0] = en0 & ph[1];
      gen[1] = en1 & ph[0];
    end
  end

  task automatic start(input logic [15:0] g, input logic m);
    @(negedge clk);
    gate = g;
    mode = m;
    som  = 1'b1;
    @(posedge clk);
    #1 som = 1'b0;
  endtask

  task automatic wait_valid(input int maxc, output int n,
                            output bit seen);
    n = 0;
    seen = 1'b0;
    for (int i = 1; i <= maxc && !seen; i++) begin
      @(posedge clk);
      @(negedge clk);
      if (valid) begin
        seen = 1'b1;
        n = i;
      end
    end
  endtask

  task automatic test_reset;
    repeat (3) @(negedge clk);
    checks++;
    if (eom !== 1'b1) begin
      errors++; $display("FAIL rst_eom got %b want 1", eom);
    end
    checks++;
    if (rdy !== 1'b0) begin
      errors++; $display("FAIL rst_rdy got %b want 0", rdy);
    end
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL rst_valid got %b want 0", valid);
    end
    checks++;
    if (adata !== 64'd0) begin
      errors++; $display("FAIL rst_adata got %h want 0", adata);
    end
    checks++;
    if (ovf !== 4'd0) begin
      errors++; $display("FAIL rst_ovf got %b want 0", ovf);
    end
    rstb = 1'b1;
    ce = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rdy !== 1'b1) begin
      errors++; $display("FAIL rdy_idle got %b want 1", rdy);
    end
  endtask

  task automatic test_single;
    int n;
    bit seen;
    en0 = 1'b1;
    repeat (8) @(negedge clk);
    start(16'd100, 1'b0);
    @(negedge clk);
    checks++;
    if (eom !== 1'b0) begin
      errors++; $display("FAIL single_eom_meas got %b want 0", eom);
    end
    wait_valid(150, n, seen);
    checks++;
    if (!seen || n + 1 != 101) begin
      errors++;
      $display("FAIL single_latency got %0d seen %b want 101", n + 1, seen);
    end
    checks++;
    if (adata !== 64'd25) begin
      errors++; $display("FAIL single_adata got %h want 25", adata);
    end
    checks++;
    if (ovf !== 4'd0) begin
      errors++; $display("FAIL single_ovf got %b want 0", ovf);
    end
    checks++;
    if (eom !== 1'b1) begin
      errors++; $display("FAIL single_eom got %b want 1", eom);
    end
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      errors++; $display("FAIL single_strobe got %b want 0", valid);
    end
    en0 = 1'b0;
  endtask

  task automatic test_sat;
    int n;
    bit seen;
    en1 = 1'b1;
    repeat (8) @(negedge clk);
    start(16'd64, 1'b0);
    wait_valid(100, n, seen);
    checks++;
    if (!seen || valid4 !== 1'b1) begin
      errors++; $display("FAIL sat_valid got %b want 1", valid4);
    end
    checks++;
    if (adata4 !== 16'h00f0) begin
      errors++; $display("FAIL sat_adata got %h want 00f0", adata4);
    end
    checks++;
    if (ovf4 !== 4'b0010) begin
      errors++; $display("FAIL sat_ovf got %b want 0010", ovf4);
    end
    checks++;
    if (adata !== 64'h0000_0000_0020_0000) begin
      errors++; $display("FAIL wide_adata got %h want 200000", adata);
    end
    checks++;
    if (ovf !== 4'd0) begin
      errors++; $display("FAIL wide_ovf got %b want 0", ovf);
    end
    en1 = 1'b0;
  endtask

  task automatic test_som_hold;
    int n;
    int n2;
    bit seen;
    bit seen2;
    en0 = 1'b1;
    repeat (8) @(negedge clk);
    gate = 16'd12;
    mode = 1'b0;
    som = 1'b1;
    repeat (8) @(negedge clk);
    som = 1'b0;
    wait_valid(40, n, seen);
    checks++;
    if (!seen || n != 5) begin
      errors++; $display("FAIL hold_latency got %0d want 5", n);
    end
    checks++;
    if (adata !== 64'd3) begin
      errors++; $display("FAIL hold_adata got %h want 3", adata);
    end
    wait_valid(30, n2, seen2);
    checks++;
    if (seen2) begin
      errors++; $display("FAIL hold_restart got %b want 0", seen2);
    end
    en0 = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_gate_zero;
    int n;
    bit seen;
    @(negedge clk);
    gate = 16'd0;
    mode = 1'b0;
    man[2] = 1'b1;
    @(negedge clk);
    som = 1'b1;
    @(posedge clk);
    #1 som = 1'b0;
    wait_valid(5, n, seen);
    checks++;
    if (!seen || n != 1) begin
      errors++; $display("FAIL g0_latency got %0d want 1", n);
    end
    checks++;
    if (adata !== 64'h0000_0001_0000_0000) begin
      errors++; $display("FAIL g0_adata got %h want 100000000", adata);
    end
    man[2] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_last_cycle;
    int n;
    bit seen;
    @(negedge clk);
    gate = 16'd5;
    mode = 1'b0;
    som = 1'b1;
    @(posedge clk);
    #1 som = 1'b0;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    man[3] = 1'b1;
    wait_valid(10, n, seen);
    checks++;
    if (!seen || n != 3) begin
      errors++; $display("FAIL last_latency got %0d want 3", n);
    end
    checks++;
    if (adata !== 64'h0001_0000_0000_0000) begin
      errors++; $display("FAIL last_adata got %h want 1<<48", adata);
    end
    man[3] = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_continuous;
    int n;
    bit seen;
    en0 = 1'b1;
    repeat (8) @(negedge clk);
    start(16'd20, 1'b1);
    @(negedge clk);
    for (int w = 0; w < 3; w++) begin
      wait_valid(40, n, seen);
      checks++;
      if (!seen || n != 20) begin
        errors++; $display("FAIL cont_period%0d got %0d want 20", w, n);
      end
      checks++;
      if (adata !== 64'd5) begin
        errors++; $display("FAIL cont_adata%0d got %h want 5", w, adata);
      end
      checks++;
      if (eom !== 1'b0) begin
        errors++; $display("FAIL cont_eom%0d got %b want 0", w, eom);
      end
    end
    repeat (5) @(negedge clk);
    mode = 1'b0;
    wait_valid(40, n, seen);
    checks++;
    if (!seen || n != 15) begin
      errors++; $display("FAIL stop_latency got %0d want 15", n);
    end
    checks++;
    if (adata !== 64'd5) begin
      errors++; $display("FAIL stop_adata got %h want 5", adata);
    end
    checks++;
    if (eom !== 1'b1) begin
      errors++; $display("FAIL stop_eom got %b want 1", eom);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (rdy !== 1'b1) begin
      errors++; $display("FAIL stop_rdy got %b want 1", rdy);
    end
    wait_valid(40, n, seen);
    checks++;
    if (seen) begin
      errors++; $display("FAIL stop_extra got %b want 0", seen);
    end
  endtask

  task automatic test_abort;
    int n;
    bit seen;
    start(16'd50, 1'b0);
    @(negedge clk);
    checks++;
    if (eom !== 1'b0) begin
      errors++; $display("FAIL abort_meas_eom got %b want 0", eom);
    end
    repeat (9) @(negedge clk);
    ce = 1'b0;
    @(negedge clk);
    checks++;
    if (eom !== 1'b1 || valid !== 1'b0) begin
      errors++;
      $display("FAIL abort_eom got %b/%b want 1/0", eom, valid);
    end
    repeat (2) @(negedge clk);
    checks++;
    if (rdy !== 1'b0) begin
      errors++; $display("FAIL abort_rdy got %b want 0", rdy);
    end
    som = 1'b1;
    @(negedge clk);
    som = 1'b0;
    wait_valid(60, n, seen);
    checks++;
    if (seen) begin
      errors++; $display("FAIL abort_valid got %b want 0", seen);
    end
    checks++;
    if (eom !== 1'b1) begin
      errors++; $display("FAIL abort_som_ign got %b want 1", eom);
    end
    checks++;
    if (adata !== 64'd5 || ovf !== 4'd0) begin
      errors++; $display("FAIL abort_keep got %h want 5", adata);
    end
    ce = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (rdy !== 1'b1) begin
      errors++; $display("FAIL abort_rdy_back got %b want 1", rdy);
    end
  endtask

  task automatic test_reset_mid;
    int n;
    bit seen;
    start(16'd100, 1'b0);
    repeat (30) @(negedge clk);
    rstb = 1'b0;
    #1;
    checks++;
    if (adata !== 64'd0 || ovf !== 4'd0) begin
      errors++; $display("FAIL rmid_data got %h/%b want 0", adata, ovf);
    end
    checks++;
    if (eom !== 1'b1 || valid !== 1'b0 || rdy !== 1'b0) begin
      errors++;
      $display("FAIL rmid_ctl got %b%b%b want 100", eom, valid, rdy);
    end
    @(negedge clk);
    rstb = 1'b1;
    repeat (3) @(negedge clk);
    start(16'd100, 1'b0);
    wait_valid(150, n, seen);
    checks++;
    if (!seen || n + 1 != 101) begin
      errors++; $display("FAIL rmid_latency got %0d want 101", n + 1);
    end
    checks++;
    if (adata !== 64'd25) begin
      errors++; $display("FAIL rmid_adata got %h want 25", adata);
    end
    en0 = 1'b0;
  endtask

  initial begin
    rstb = 1'b0;
    ce   = 1'b0;
    som  = 1'b0;
    mode = 1'b0;
    gate = 16'd0;
    en0  = 1'b0;
    en1  = 1'b0;
    man  = 4'd0;
    test_reset;
    test_single;
    test_sat;
    test_som_hold;
    test_gate_zero;
    test_last_cycle;
    test_continuous;
    test_abort;
    test_reset_mid;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
